// File: rtl/atmega_tim_prescaler.sv
// Shared prescaler for the ATmega-style 8-bit timers: owns GTCCR, runs the
// 10-bit prescale counter and emits registered tick and T-pin edge strobes.
module atmega_tim_prescaler #(
  parameter int                           BUS_ADDR_DATA_LEN = 8,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] GTCCR_ADDR        = 8'h43
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         halt,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr_dat,
  input  logic                         wr_dat,
  input  logic                         rd_dat,
  input  logic [7:0]                   bus_dat_in,
  output logic [7:0]                   bus_dat_out,
  input  logic                         t,
  output logic                         clk8,
  output logic                         clk64,
  output logic                         clk256,
  output logic                         clk1024,
  output logic                         t0_rise,
  output logic                         t0_fall
);

  logic       tsm_r;
  logic       psrsync_r;
  logic [9:0] cnt_r;
  logic       clk8_r;
  logic       clk64_r;
  logic       clk256_r;
  logic       clk1024_r;
  logic       s1_r;
  logic       s2_r;
  logic       s3_r;
  logic       t0_rise_r;
  logic       t0_fall_r;

  logic       sel_s;
  logic       wr_hit_s;
  logic       clr_s;
  logic       hold_s;
  logic       run_s;
  logic [9:0] cnt_nxt_s;
  logic       psrsync_nxt_s;
  logic [7:0] rd_data_s;
  logic       unused_bits_s;

  // Reserved GTCCR bits (PSRASY and 6:2) are accepted on the bus but discarded.
  assign unused_bits_s = ^bus_dat_in[6:1];

  // Address decode, clearing write detection and the run qualifier.
  always_comb begin
    sel_s    = (addr_dat == GTCCR_ADDR);
    wr_hit_s = wr_dat & sel_s;
    clr_s    = wr_hit_s & bus_dat_in[0];
    hold_s   = tsm_r & psrsync_r;
    run_s    = ~halt & ~hold_s & ~clr_s;
  end

  // PSRSYNC only sticks when TSM is written high; TSM = 0 releases the hold.
  always_comb begin
    if (bus_dat_in[7]) begin
      psrsync_nxt_s = bus_dat_in[0];
    end else begin
      psrsync_nxt_s = 1'b0;
    end
  end

  // Next counter value: clear beats hold, hold beats halt, halt beats increment.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (clr_s) begin
      cnt_nxt_s = 10'd0;
    end else if (hold_s) begin
      cnt_nxt_s = 10'd0;
    end else if (halt) begin
      cnt_nxt_s = cnt_r;
    end else begin
      cnt_nxt_s = cnt_r + 10'd1;
    end
  end

  // Combinational OR-bus read path.
  always_comb begin
    if (rd_dat & sel_s) begin
      rd_data_s = {tsm_r, 6'b00_0000, psrsync_r};
    end else begin
      rd_data_s = 8'h00;
    end
  end

  // GTCCR register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tsm_r     <= 1'b0;
      psrsync_r <= 1'b0;
    end else if (wr_hit_s) begin
      tsm_r     <= bus_dat_in[7];
      psrsync_r <= psrsync_nxt_s;
    end else begin
      tsm_r     <= tsm_r;
      psrsync_r <= psrsync_r;
    end
  end

  // Prescale counter and registered tick strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r     <= 10'd0;
      clk8_r    <= 1'b0;
      clk64_r   <= 1'b0;
      clk256_r  <= 1'b0;
      clk1024_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_nxt_s;
      clk8_r    <= run_s & (cnt_r[2:0] == 3'd7);
      clk64_r   <= run_s & (cnt_r[5:0] == 6'd63);
      clk256_r  <= run_s & (cnt_r[7:0] == 8'd255);
      clk1024_r <= run_s & (cnt_r == 10'd1023);
    end
  end

  // T pin: two-flop synchroniser, delay flop, registered edge strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_r      <= 1'b0;
      s2_r      <= 1'b0;
      s3_r      <= 1'b0;
      t0_rise_r <= 1'b0;
      t0_fall_r <= 1'b0;
    end else begin
      s1_r      <= t;
      s2_r      <= s1_r;
      s3_r      <= s2_r;
      t0_rise_r <= s2_r & ~s3_r;
      t0_fall_r <= ~s2_r & s3_r;
    end
  end

  assign bus_dat_out = rd_data_s;
  assign clk8        = clk8_r;
  assign clk64       = clk64_r;
  assign clk256      = clk256_r;
  assign clk1024     = clk1024_r;
  assign t0_rise     = t0_rise_r;
  assign t0_fall     = t0_fall_r;

endmodule

// File: tb/tb_atmega_tim_prescaler.sv
// Directed self-checking bench for atmega_tim_prescaler.
module tb_atmega_tim_prescaler;

  logic       clk;
  logic       rst;
  logic       halt;
  logic [7:0] addr_dat;
  logic       wr_dat;
  logic       rd_dat;
  logic [7:0] bus_dat_in;
  logic [7:0] bus_dat_out;
  logic       t;
  logic       clk8;
  logic       clk64;
  logic       clk256;
  logic       clk1024;
  logic       t0_rise;
  logic       t0_fall;

  int n_vec;
  int n_err;

  atmega_tim_prescaler dut (
    .clk         (clk),
    .rst         (rst),
    .halt        (halt),
    .addr_dat    (addr_dat),
    .wr_dat      (wr_dat),
    .rd_dat      (rd_dat),
    .bus_dat_in  (bus_dat_in),
    .bus_dat_out (bus_dat_out),
    .t           (t),
    .clk8        (clk8),
    .clk64       (clk64),
    .clk256      (clk256),
    .clk1024     (clk1024),
    .t0_rise     (t0_rise),
    .t0_fall     (t0_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge and settle 1 time unit.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-edge write to GTCCR (or any address).
  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    addr_dat   = a;
    bus_dat_in = d;
    wr_dat     = 1'b1;
    tick();
    wr_dat     = 1'b0;
    bus_dat_in = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b0; halt = 1'b0; addr_dat = 8'h43; wr_dat = 1'b0; rd_dat = 1'b1;
    bus_dat_in = 8'h00; t = 1'b0;
    tick(); tick();
    n_vec++; if ({clk8, clk64, clk256, clk1024} !== 4'b0000) begin n_err++; $display("FAIL reset_ticks got %b exp 0000", {clk8, clk64, clk256, clk1024}); end
    n_vec++; if ({t0_rise, t0_fall} !== 2'b00) begin n_err++; $display("FAIL reset_t0 got %b exp 00", {t0_rise, t0_fall}); end
    n_vec++; if (bus_dat_out !== 8'h00) begin n_err++; $display("FAIL reset_bus got %h exp 00", bus_dat_out); end
    rd_dat = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_free_run();
    int c8, c64, c256, c1024;
    c8 = 0; c64 = 0; c256 = 0; c1024 = 0;
    for (int e = 1; e <= 2048; e++) begin
      tick();
      c8 += int'(clk8); c64 += int'(clk64); c256 += int'(clk256); c1024 += int'(clk1024);
      n_vec++; if (clk8 !== ((e % 8) == 0)) begin n_err++; $display("FAIL run_clk8 edge %0d got %b exp %b", e, clk8, (e % 8) == 0); end
      n_vec++; if (clk64 !== ((e % 64) == 0)) begin n_err++; $display("FAIL run_clk64 edge %0d got %b exp %b", e, clk64, (e % 64) == 0); end
      n_vec++; if (clk256 !== ((e % 256) == 0)) begin n_err++; $display("FAIL run_clk256 edge %0d got %b exp %b", e, clk256, (e % 256) == 0); end
      n_vec++; if (clk1024 !== ((e % 1024) == 0)) begin n_err++; $display("FAIL run_clk1024 edge %0d got %b exp %b", e, clk1024, (e % 1024) == 0); end
    end
    n_vec++; if (c8 !== 256) begin n_err++; $display("FAIL count_clk8 got %0d exp 256", c8); end
    n_vec++; if (c64 !== 32) begin n_err++; $display("FAIL count_clk64 got %0d exp 32", c64); end
    n_vec++; if (c256 !== 8) begin n_err++; $display("FAIL count_clk256 got %0d exp 8", c256); end
    n_vec++; if (c1024 !== 2) begin n_err++; $display("FAIL count_clk1024 got %0d exp 2", c1024); end
  endtask

  // Counter is 0 on entry (2048 edges after reset).
  task automatic test_clear();
    for (int e = 1; e <= 500; e++) tick();
    bus_write(8'h43, 8'h01);
    rd_dat = 1'b1; addr_dat = 8'h43; #1;
    n_vec++; if (bus_dat_out !== 8'h00) begin n_err++; $display("FAIL clr_readback got %h exp 00", bus_dat_out); end
    rd_dat = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      tick();
      n_vec++; if (clk8 !== ((j % 8) == 0)) begin n_err++; $display("FAIL clr_clk8 edge k+%0d got %b exp %b", j, clk8, (j % 8) == 0); end
    end
    // cnt = 16 now; reach 511 where three strobes would otherwise fire.
    for (int e = 1; e <= 495; e++) tick();
    bus_write(8'h43, 8'h01);
    n_vec++; if ({clk8, clk64, clk256} !== 3'b000) begin n_err++; $display("FAIL clr_suppress got %b exp 000", {clk8, clk64, clk256}); end
  endtask

  task automatic test_hold();
    bus_write(8'h43, 8'h81);
    rd_dat = 1'b1; addr_dat = 8'h43; #1;
    n_vec++; if (bus_dat_out !== 8'h81) begin n_err++; $display("FAIL hold_readback got %h exp 81", bus_dat_out); end
    rd_dat = 1'b0;
    for (int j = 1; j <= 100; j++) begin
      tick();
      n_vec++; if ({clk8, clk64, clk256, clk1024} !== 4'b0000) begin n_err++; $display("FAIL hold_quiet cycle %0d got %b exp 0000", j, {clk8, clk64, clk256, clk1024}); end
    end
    bus_write(8'h43, 8'h00);
    for (int j = 1; j <= 8; j++) begin
      tick();
      n_vec++; if (clk8 !== (j == 8)) begin n_err++; $display("FAIL release_clk8 edge k+%0d got %b exp %b", j, clk8, j == 8); end
    end
  endtask

  task automatic test_halt();
    bus_write(8'h43, 8'h01);
    for (int e = 1; e <= 21; e++) begin
      tick();
      n_vec++; if (clk8 !== (e == 13 || e == 21)) begin n_err++; $display("FAIL halt_clk8 edge %0d got %b exp %b", e, clk8, e == 13 || e == 21); end
      if (e == 3) halt = 1'b1;
      if (e == 8) halt = 1'b0;
    end
  endtask

  task automatic test_t_pin();
    for (int e = 1; e <= 25; e++) begin
      tick();
      n_vec++; if (t0_rise !== (e == 12)) begin n_err++; $display("FAIL t0_rise edge %0d got %b exp %b", e, t0_rise, e == 12); end
      n_vec++; if (t0_fall !== (e == 22)) begin n_err++; $display("FAIL t0_fall edge %0d got %b exp %b", e, t0_fall, e == 22); end
      if (e == 9) t = 1'b1;
      if (e == 19) t = 1'b0;
    end
  endtask

  task automatic test_addr_decode();
    bus_write(8'h43, 8'h81);
    rd_dat = 1'b1; addr_dat = 8'h44; #1;
    n_vec++; if (bus_dat_out !== 8'h00) begin n_err++; $display("FAIL rd_wrong_addr got %h exp 00", bus_dat_out); end
    addr_dat = 8'h43; #1;
    n_vec++; if (bus_dat_out !== 8'h81) begin n_err++; $display("FAIL rd_right_addr got %h exp 81", bus_dat_out); end
    rd_dat = 1'b0; #1;
    n_vec++; if (bus_dat_out !== 8'h00) begin n_err++; $display("FAIL rd_no_strobe got %h exp 00", bus_dat_out); end
    bus_write(8'h43, 8'h00);
    bus_write(8'h44, 8'h81);
    rd_dat = 1'b1; addr_dat = 8'h43; #1;
    n_vec++; if (bus_dat_out !== 8'h00) begin n_err++; $display("FAIL wr_wrong_addr got %h exp 00", bus_dat_out); end
    rd_dat = 1'b0;
  endtask

  task automatic test_async_reset();
    bus_write(8'h43, 8'h01);
    bus_write(8'h43, 8'h80);
    for (int j = 2; j <= 8; j++) tick();
    n_vec++; if (clk8 !== 1'b1) begin n_err++; $display("FAIL pre_rst_clk8 got %b exp 1", clk8); end
    rd_dat = 1'b1; addr_dat = 8'h43; #1;
    n_vec++; if (bus_dat_out !== 8'h80) begin n_err++; $display("FAIL pre_rst_bus got %h exp 80", bus_dat_out); end
    t = 1'b1;
    rst = 1'b0; #1;
    n_vec++; if ({clk8, clk64, clk256, clk1024, t0_rise, t0_fall} !== 6'b000000) begin n_err++; $display("FAIL async_rst_strobes got %b exp 000000", {clk8, clk64, clk256, clk1024, t0_rise, t0_fall}); end
    n_vec++; if (bus_dat_out !== 8'h00) begin n_err++; $display("FAIL async_rst_bus got %h exp 00", bus_dat_out); end
    rd_dat = 1'b0;
    tick();
    rst = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      n_vec++; if (t0_rise !== (e == 3)) begin n_err++; $display("FAIL rst_t_rise edge %0d got %b exp %b", e, t0_rise, e == 3); end
      n_vec++; if (clk8 !== (e == 8)) begin n_err++; $display("FAIL rst_clk8 edge %0d got %b exp %b", e, clk8, e == 8); end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_free_run();
    test_clear();
    test_hold();
    test_halt();
    test_t_pin();
    test_addr_decode();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
